// File: rtl/branch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_pkg                                                 |
// | Brief   : Shared branch opcodes, CCR flag positions, counter states. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package branch_pkg;

    localparam logic [2:0] BU_NONE = 3'b000;
    localparam logic [2:0] BU_JZ   = 3'b001;
    localparam logic [2:0] BU_JN   = 3'b010;
    localparam logic [2:0] BU_JC   = 3'b011;
    localparam logic [2:0] BU_JV   = 3'b100;
    localparam logic [2:0] BU_LOOP = 3'b101;
    localparam logic [2:0] BU_JMP  = 3'b110;
    localparam logic [2:0] BU_RSVD = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // The reserved opcode behaves exactly like "no branch".
    function automatic logic is_branch_op(input logic [2:0] op);
        return (op != BU_NONE) && (op != BU_RSVD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_sat_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bht_sat_ctr                                                |
// | Brief   : 2-bit saturating counter next-state function.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bht_sat_ctr
    import branch_pkg::*;
(
    input  logic [1:0] i_state,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_state;
        if (i_taken) begin
            if (i_state != CTR_ST) begin
                o_next = i_state + 2'd1;
            end
        end else if (i_state != CTR_SNT) begin
            o_next = i_state - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_predict_unit                                        |
// | Brief   : Bimodal BHT predictor with same-cycle branch resolution.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int         PC_W     = 8,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] f_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [2:0]      ex_bu_op,
    input  logic [3:0]      ex_flags,
    input  logic            ex_z_now,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_target,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic            br_taken,
    output logic [15:0]     br_cnt,
    output logic [15:0]     mp_cnt
);

    localparam int c_DEPTH = 1 << IDX_W;

    logic [1:0]       r_bht_q [c_DEPTH];
    logic [1:0]       w_bht_d [c_DEPTH];
    logic [15:0]      r_br_cnt_q;
    logic [15:0]      w_br_cnt_d;
    logic [15:0]      r_mp_cnt_q;
    logic [15:0]      w_mp_cnt_d;
    logic             w_is_branch;
    logic             w_cond;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_ctr_next;
    logic             w_unused_fpc_hi;

    assign w_unused_fpc_hi = ^f_pc[PC_W-1:IDX_W];

    // Read port sees the registered table only: no write-to-read bypass.
    assign pred_taken = r_bht_q[f_pc[IDX_W-1:0]][1];

    assign w_is_branch = ex_valid && is_branch_op(ex_bu_op);
    assign w_upd_idx   = ex_pc[IDX_W-1:0];

    always_comb begin
        w_cond = 1'b0;
        case (ex_bu_op)
            BU_JZ:   w_cond = ex_flags[FLAG_Z];
            BU_JN:   w_cond = ex_flags[FLAG_N];
            BU_JC:   w_cond = ex_flags[FLAG_C];
            BU_JV:   w_cond = ex_flags[FLAG_V];
            BU_LOOP: w_cond = !ex_z_now;
            BU_JMP:  w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign br_taken    = !rst && w_is_branch && w_cond;
    assign flush       = !rst && w_is_branch && (w_cond != ex_pred_taken);
    assign redirect_pc = br_taken ? ex_target : ex_pc + {{(PC_W-1){1'b0}}, 1'b1};

    bht_sat_ctr u_sat_ctr (
        .i_state (r_bht_q[w_upd_idx]),
        .i_taken (w_cond),
        .o_next  (w_ctr_next)
    );

    always_comb begin
        for (int i = 0; i < c_DEPTH; i++) begin
            w_bht_d[i] = r_bht_q[i];
        end
        if (w_is_branch) begin
            w_bht_d[w_upd_idx] = w_ctr_next;
        end
    end

    always_comb begin
        w_br_cnt_d = r_br_cnt_q;
        w_mp_cnt_d = r_mp_cnt_q;
        if (w_is_branch && (r_br_cnt_q != 16'hFFFF)) begin
            w_br_cnt_d = r_br_cnt_q + 16'd1;
        end
        if (flush && (r_mp_cnt_q != 16'hFFFF)) begin
            w_mp_cnt_d = r_mp_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bht_q[i] <= CTR_INIT;
            end
            r_br_cnt_q <= 16'd0;
            r_mp_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bht_q[i] <= w_bht_d[i];
            end
            r_br_cnt_q <= w_br_cnt_d;
            r_mp_cnt_q <= w_mp_cnt_d;
        end
    end

    assign br_cnt = r_br_cnt_q;
    assign mp_cnt = r_mp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_branch_predict_unit                                     |
// | Brief   : Randomised scoreboard bench for branch_predict_unit.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  f_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [7:0]  ex_pc;
    logic [2:0]  ex_bu_op;
    logic [3:0]  ex_flags;
    logic        ex_z_now;
    logic        ex_pred_taken;
    logic [7:0]  ex_target;
    logic        flush;
    logic [7:0]  redirect_pc;
    logic        br_taken;
    logic [15:0] br_cnt;
    logic [15:0] mp_cnt;

    branch_predict_unit #(.PC_W(8), .IDX_W(4), .CTR_INIT(2'b01)) dut (
        .clk           (clk),
        .rst           (rst),
        .f_pc          (f_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_bu_op      (ex_bu_op),
        .ex_flags      (ex_flags),
        .ex_z_now      (ex_z_now),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_taken      (br_taken),
        .br_cnt        (br_cnt),
        .mp_cnt        (mp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_rst;
        logic        pred;
        logic        flush;
        logic        brt;
        logic [7:0]  rpc;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: plain integer counters 0..3 and event tallies.
    int   m_bht [16];
    int   m_bc;
    int   m_mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic drive(input logic r, input logic [7:0] fpc, input logic v,
                         input logic [2:0] op, input logic [3:0] fl, input logic zn,
                         input logic pp, input logic [7:0] pc, input logic [7:0] tgt);
        exp_t e;
        bit   is_br;
        bit   tk;
        @(posedge clk);
        #1;
        rst = r; f_pc = fpc; ex_valid = v; ex_bu_op = op; ex_flags = fl;
        ex_z_now = zn; ex_pred_taken = pp; ex_pc = pc; ex_target = tgt;
        if (r) model_reset();
        is_br = v && (op >= 3'd1) && (op <= 3'd6);
        case (op)
            3'd1: tk = fl[0];
            3'd2: tk = fl[1];
            3'd3: tk = fl[2];
            3'd4: tk = fl[3];
            3'd5: tk = !zn;
            3'd6: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        tk = tk && is_br && !r;
        e.in_rst = r;
        e.pred   = m_bht[fpc % 16] >= 2;
        e.brt    = tk;
        e.flush  = !r && is_br && (tk != pp);
        e.rpc    = tk ? tgt : 8'((int'(pc) + 1) % 256);
        e.bc     = 16'(m_bc);
        e.mc     = 16'(m_mc);
        q.push_back(e);
        if (!r && is_br) begin
            m_bht[pc % 16] = tk ? ((m_bht[pc % 16] == 3) ? 3 : m_bht[pc % 16] + 1)
                                : ((m_bht[pc % 16] == 0) ? 0 : m_bht[pc % 16] - 1);
            if (m_bc < 65535) m_bc++;
            if (e.flush && m_mc < 65535) m_mc++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pred_taken", 32'(pred_taken), 32'(e.pred));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("br_taken", 32'(br_taken), 32'(e.brt));
                if (!e.in_rst) chk("redirect_pc", 32'(redirect_pc), 32'(e.rpc));
                chk("br_cnt", 32'(br_cnt), 32'(e.bc));
                chk("mp_cnt", 32'(mp_cnt), 32'(e.mc));
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; f_pc = '0; ex_valid = 1'b0; ex_bu_op = '0; ex_flags = '0;
        ex_z_now = 1'b0; ex_pred_taken = 1'b0; ex_pc = '0; ex_target = '0;
        model_reset();

        // Reset sweep with a mispredicting JMP presented: outputs must stay forced low.
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 1, 3'b110, 4'hF, 0, 0, 8'(i), 8'h77);

        // JZ taken, predicted not-taken; then observe entry 0 became weak-taken.
        drive(0, 8'h00, 1, 3'b001, 4'b0001, 0, 0, 8'h10, 8'h40);
        drive(0, 8'h00, 0, 3'b000, 4'b0000, 0, 0, 8'h00, 8'h00);
        // LOOP falls through at ex_pc all-ones: redirect wraps to 0.
        drive(0, 8'h0F, 1, 3'b101, 4'b0000, 1, 1, 8'hFF, 8'h20);
        drive(0, 8'h0F, 0, 3'b000, 4'b0000, 0, 0, 8'h00, 8'h00);
        // Saturation: five taken JMPs at 0x03.
        for (int i = 0; i < 5; i++) drive(0, 8'h03, 1, 3'b110, 4'h0, 0, 1, 8'h03, 8'h80);
        drive(0, 8'h03, 1, 3'b001, 4'b0000, 0, 1, 8'h13, 8'h80);
        // Same-index collision at 0x05.
        drive(0, 8'h05, 1, 3'b110, 4'h0, 0, 0, 8'h05, 8'h55);
        drive(0, 8'h05, 0, 3'b000, 4'h0, 0, 0, 8'h05, 8'h55);
        // Non-branch, reserved, and invalid cycles that would otherwise mispredict.
        drive(0, 8'h05, 1, 3'b000, 4'hF, 0, 1, 8'h05, 8'h11);
        drive(0, 8'h05, 1, 3'b111, 4'hF, 0, 1, 8'h05, 8'h11);
        drive(0, 8'h05, 0, 3'b001, 4'hF, 0, 0, 8'h05, 8'h11);
        drive(0, 8'h03, 0, 3'b000, 4'h0, 0, 0, 8'h00, 8'h00);
        // Mid-sequence reset: checked before the next rising edge.
        drive(1, 8'h03, 0, 3'b000, 4'h0, 0, 0, 8'h00, 8'h00);
        drive(0, 8'h03, 1, 3'b110, 4'h0, 0, 0, 8'h03, 8'h90);
        drive(0, 8'h03, 0, 3'b000, 4'h0, 0, 0, 8'h03, 8'h00);

        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) == 0), 8'($urandom), ($urandom_range(0, 7) != 0),
                  3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom_range(0, 31) == 0 ? 255 : $urandom), 8'($urandom));
        end

        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
